// File: rtl/ssd_scan_ctrl.sv
// rtl/ssd_scan_ctrl.sv - 4-digit seven-segment scan controller with frame-aligned double buffering
module ssd_scan_ctrl #(
    parameter int SCAN_DIV     = 25000,
    parameter int BLANK_CYCLES = 100,
    parameter int CNT_W        = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        disp_on,
    input  logic        load,
    input  logic [15:0] digit_val,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    output logic [3:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        frame_done,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam state_t           SLOT_START = (BLANK_CYCLES > 0) ? BLANK : SHOW;

    state_t           state, state_d;
    logic [1:0]       idx, idx_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             frame_start;

    logic [15:0] act_val, act_val_d, pend_val, pend_val_d;
    logic [3:0]  act_dp, act_dp_d, pend_dp, pend_dp_d;
    logic [3:0]  act_en, act_en_d, pend_en, pend_en_d;
    logic        pend_valid, pend_valid_d;

    logic [3:0] an_n_d;
    logic [6:0] seg_n_d;
    logic       dp_n_d, frame_done_d, busy_d, lit;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    always_comb begin
        state_d     = state;
        idx_d       = idx;
        cnt_d       = cnt;
        frame_start = 1'b0;
        if (state != IDLE && !disp_on) begin
            state_d = IDLE;
            idx_d   = 2'd0;
            cnt_d   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (disp_on) begin
                        state_d     = SLOT_START;
                        idx_d       = 2'd0;
                        cnt_d       = '0;
                        frame_start = 1'b1;
                    end
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        state_d     = SLOT_START;
                        cnt_d       = '0;
                        idx_d       = idx + 2'd1;
                        frame_start = (idx == 2'd3);
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A load landing on the frame-start edge bypasses pending and goes live immediately.
    always_comb begin
        act_val_d    = act_val;
        act_dp_d     = act_dp;
        act_en_d     = act_en;
        pend_val_d   = pend_val;
        pend_dp_d    = pend_dp;
        pend_en_d    = pend_en;
        pend_valid_d = pend_valid;
        if (frame_start && load) begin
            act_val_d    = digit_val;
            act_dp_d     = dp_in;
            act_en_d     = digit_en;
            pend_valid_d = 1'b0;
        end else if (frame_start && pend_valid) begin
            act_val_d    = pend_val;
            act_dp_d     = pend_dp;
            act_en_d     = pend_en;
            pend_valid_d = 1'b0;
        end else if (load) begin
            pend_val_d   = digit_val;
            pend_dp_d    = dp_in;
            pend_en_d    = digit_en;
            pend_valid_d = 1'b1;
        end
    end

    // Outputs decode from the next state so they switch on the same edge as the state.
    always_comb begin
        lit          = (state_d == SHOW) && act_en_d[idx_d];
        an_n_d       = lit ? ~(4'b0001 << idx_d) : 4'hF;
        seg_n_d      = lit ? hex_to_seg(act_val_d[{idx_d, 2'b00} +: 4]) : 7'h7F;
        dp_n_d       = lit ? ~act_dp_d[idx_d] : 1'b1;
        frame_done_d = (state_d == SHOW) && (idx_d == 2'd3) && (cnt_d == SHOW_LAST);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= 2'd0;
            cnt        <= '0;
            act_val    <= '0;
            act_dp     <= '0;
            act_en     <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_en    <= '0;
            pend_valid <= 1'b0;
            an_n       <= 4'hF;
            seg_n      <= 7'h7F;
            dp_n       <= 1'b1;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            cnt        <= cnt_d;
            act_val    <= act_val_d;
            act_dp     <= act_dp_d;
            act_en     <= act_en_d;
            pend_val   <= pend_val_d;
            pend_dp    <= pend_dp_d;
            pend_en    <= pend_en_d;
            pend_valid <= pend_valid_d;
            an_n       <= an_n_d;
            seg_n      <= seg_n_d;
            dp_n       <= dp_n_d;
            frame_done <= frame_done_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb/tb_ssd_scan_ctrl.sv - scoreboard bench for ssd_scan_ctrl (slow and fast scan instances)
module tb_ssd_scan_ctrl;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        r0 = 1'b1, on0 = 1'b0, ld0 = 1'b0;
    logic        r1 = 1'b1, on1 = 1'b0, ld1 = 1'b0;
    logic [15:0] dval = 16'h0;
    logic [3:0]  dpv = 4'h0, env = 4'h0;

    logic [3:0] an0, an1;
    logic [6:0] seg0, seg1;
    logic       dpn0, dpn1, fd0, fd1, busy0, busy1;

    int total = 0;
    int bad   = 0;

    logic [13:0] q0[$];
    logic [13:0] q1[$];

    logic [6:0] hex_tb [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    localparam logic [13:0] DARK = {1'b0, 1'b0, 1'b1, 7'h7F, 4'hF};

    ssd_scan_ctrl #(.SCAN_DIV(4), .BLANK_CYCLES(2), .CNT_W(16)) dut_slow (
        .clock(clock), .reset(r0), .disp_on(on0), .load(ld0),
        .digit_val(dval), .dp_in(dpv), .digit_en(env),
        .an_n(an0), .seg_n(seg0), .dp_n(dpn0), .frame_done(fd0), .busy(busy0)
    );

    ssd_scan_ctrl #(.SCAN_DIV(1), .BLANK_CYCLES(0), .CNT_W(16)) dut_fast (
        .clock(clock), .reset(r1), .disp_on(on1), .load(ld1),
        .digit_val(dval), .dp_in(dpv), .digit_en(env),
        .an_n(an1), .seg_n(seg1), .dp_n(dpn1), .frame_done(fd1), .busy(busy1)
    );

    // Expected {busy, frame_done, dp_n, seg_n, an_n} at position p of a scanning frame.
    function automatic logic [13:0] model(input logic [15:0] v, input logic [3:0] dp,
                                          input logic [3:0] en, input int p, input int b, input int s);
        int d, w;
        logic lit;
        logic [3:0] an;
        logic [6:0] sg;
        logic dn, fd;
        d   = p / (b + s);
        w   = p % (b + s);
        lit = (w >= b) && en[d];
        an  = lit ? ~(4'b0001 << d) : 4'hF;
        sg  = lit ? hex_tb[v[d*4 +: 4]] : 7'h7F;
        dn  = lit ? ~dp[d] : 1'b1;
        fd  = (p == 4 * (b + s) - 1);
        return {1'b1, fd, dn, sg, an};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input int which, input logic [15:0] v, input logic [3:0] dp,
                        input logic [3:0] en, input int n);
        for (int p = 0; p < n; p++) begin
            if (which == 0) q0.push_back(model(v, dp, en, p, 2, 4));
            else            q1.push_back(model(v, dp, en, p % 4, 0, 1));
        end
    endtask

    task automatic push_dark(input int which, input int n);
        for (int i = 0; i < n; i++) begin
            if (which == 0) q0.push_back(DARK);
            else            q1.push_back(DARK);
        end
    endtask

    task automatic drain(input int which, input int n, input string name);
        logic [13:0] got, exp;
        for (int i = 0; i < n; i++) begin
            step();
            got = (which == 0) ? {busy0, fd0, dpn0, seg0, an0} : {busy1, fd1, dpn1, seg1, an1};
            total++;
            if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
                bad++;
                $display("FAIL %s cycle %0d: scoreboard empty, got %h", name, i, got);
            end else begin
                exp = (which == 0) ? q0.pop_front() : q1.pop_front();
                if (got !== exp) begin
                    bad++;
                    $display("FAIL %s cycle %0d: got {busy,fd,dp_n,seg_n,an_n}=%h expected %h",
                             name, i, got, exp);
                end
            end
        end
    endtask

    task automatic test_reset();
        r0 = 1'b1; r1 = 1'b1; on0 = 1'b0; on1 = 1'b0;
        step();
        step();
        total++;
        if ({busy0, fd0, dpn0, seg0, an0} !== DARK) begin
            bad++;
            $display("FAIL reset_slow: got %h expected %h", {busy0, fd0, dpn0, seg0, an0}, DARK);
        end
        total++;
        if ({busy1, fd1, dpn1, seg1, an1} !== DARK) begin
            bad++;
            $display("FAIL reset_fast: got %h expected %h", {busy1, fd1, dpn1, seg1, an1}, DARK);
        end
        r0 = 1'b0; r1 = 1'b0;
        push_dark(0, 10);
        drain(0, 10, "idle_hold_slow");
        push_dark(1, 4);
        drain(1, 4, "idle_hold_fast");
    endtask

    task automatic test_scan();
        dval = 16'h8A10; dpv = 4'b0100; env = 4'hF;
        ld0 = 1'b1;
        step();
        ld0 = 1'b0;
        on0 = 1'b1;
        push(0, 16'h8A10, 4'b0100, 4'hF, 24);
        push(0, 16'h8A10, 4'b0100, 4'hF, 24);
        drain(0, 48, "scan_8a10");
    endtask

    task automatic test_midload();
        push(0, 16'h8A10, 4'b0100, 4'hF, 24);
        drain(0, 8, "midload_pre");
        dval = 16'hFFFF; dpv = 4'h0; env = 4'hF;
        ld0 = 1'b1;
        drain(0, 1, "midload_strobe");
        ld0 = 1'b0;
        drain(0, 15, "midload_rest");
        push(0, 16'hFFFF, 4'h0, 4'hF, 24);
        drain(0, 24, "midload_next");
    endtask

    task automatic test_enable_mask();
        push(0, 16'hFFFF, 4'h0, 4'hF, 24);
        drain(0, 5, "mask_pre");
        dval = 16'h8A10; dpv = 4'b0100; env = 4'b1010;
        ld0 = 1'b1;
        drain(0, 1, "mask_strobe");
        ld0 = 1'b0;
        drain(0, 18, "mask_rest");
        push(0, 16'h8A10, 4'b0100, 4'b1010, 24);
        drain(0, 24, "mask_frame");
    endtask

    task automatic test_disp_off();
        push(0, 16'h8A10, 4'b0100, 4'b1010, 15);
        drain(0, 15, "off_partial");
        on0 = 1'b0;
        push_dark(0, 3);
        drain(0, 3, "off_idle");
        on0 = 1'b1;
        push(0, 16'h8A10, 4'b0100, 4'b1010, 24);
        drain(0, 24, "off_restart");
    endtask

    task automatic test_fast_and_reset();
        dval = 16'h8A10; dpv = 4'b0100; env = 4'hF;
        ld1 = 1'b1;
        step();
        ld1 = 1'b0;
        on1 = 1'b1;
        push(1, 16'h8A10, 4'b0100, 4'hF, 12);
        drain(1, 12, "fast_scan");
        push(1, 16'h8A10, 4'b0100, 4'hF, 2);
        drain(1, 2, "fast_partial");
        r1 = 1'b1;
        step();
        total++;
        if ({busy1, fd1, dpn1, seg1, an1} !== DARK) begin
            bad++;
            $display("FAIL midframe_reset: got %h expected %h", {busy1, fd1, dpn1, seg1, an1}, DARK);
        end
        r1 = 1'b0;
        push(1, 16'h0000, 4'h0, 4'h0, 8);
        drain(1, 8, "fast_after_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_scan();
        test_midload();
        test_enable_mask();
        test_disp_off();
        test_fast_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
